ef_bus_arbiter: RTL and testbench
=================================

Name: ef_bus_arbiter

Overview:
- Sequences and shares the board's multiplexed Flash/Ethernet external bus (ef_a, ef_d) between two internal requesters: the flash port and the Ethernet controller port.
- Grants the bus round-robin and generates per-device chip-select and strobe timing with programmable setup, access and hold cycles.
- Inserts bus-turnaround cycles when ownership changes between devices.
- Sits between the Nios II Avalon-side bridges and the top-level pads; the top level owns the ef_d tristate.

Parameters:
AW, 26, external address width (ef_a[AW:1])
DW, 32, external data width
FL_SETUP, 2, flash address/CE setup cycles before strobe (1..15)
FL_ACCESS, 4, flash strobe-low cycles (1..15)
FL_HOLD, 1, flash cycles after strobe release (1..15)
EN_SETUP, 1, Ethernet setup cycles (1..15)
EN_ACCESS, 3, Ethernet strobe-low cycles (1..15)
EN_HOLD, 1, Ethernet hold cycles (1..15)
TURN, 1, idle cycles inserted on device switch (0..15)

Ports:
clk  in  1  system clock (32.768 MHz)
rst  in  1  asynchronous active-high reset
fl_req  in  1  flash port request; held until fl_ack
fl_we  in  1  1 = write, 0 = read
fl_addr  in  AW  word address
fl_wdata  in  DW  write data
fl_rdata  out  DW  read data
fl_ack  out  1  one-cycle completion pulse
en_req  in  1  Ethernet port request
en_we  in  1  1 = write
en_be  in  4  byte enables, active high
en_addr  in  AW  address
en_wdata  in  DW  write data
en_rdata  out  DW  read data
en_ack  out  1  one-cycle completion pulse
ef_a  out  AW  shared address bus
ef_d_o  out  DW  shared data out
ef_d_oe  out  1  data output enable
ef_d_i  in  DW  shared data in
flash_ce_n, flash_oe_n, flash_we_n  out  1 each  flash controls, active low
enet_rd_n, enet_wr_n  out  1 each  Ethernet strobes, active low
enet_be_n  out  4  Ethernet byte enables, active low

Behaviour:
- All outputs registered. Reset (asynchronous, also mid-transaction) forces the following; an in-flight transaction is dropped with no ack:
  - state IDLE
  - all *_n outputs = 1; enet_be_n = 4'hF
  - ef_d_oe = 0; ef_a = 0; ef_d_o = 0
  - acks = 0; rdata = 0
  - last_dev = NONE; rr_pri = FLASH
- FSM states: IDLE, TURN, SETUP, ACCESS, HOLD. A single 4-bit counter loads (N-1) on state entry.
- IDLE arbitration:
  - Eligible request = req high AND that port's ack not high this cycle.
  - One eligible request: grant it.
  - Both eligible: grant rr_pri; rr_pri then flips to the other port.
  - Grant latches we, addr, be and wdata into internal registers.
  - Next state is TURN if last_dev is neither NONE nor the granted device and TURN > 0; otherwise SETUP.
- TURN: all strobes/CE high, ef_d_oe = 0; lasts TURN cycles.
- SETUP: ef_a = latched address.
  - Flash: flash_ce_n = 0.
  - Ethernet: enet_be_n = ~be.
  - Writes: ef_d_oe = 1, ef_d_o = wdata.
  - Lasts X_SETUP cycles.
- ACCESS: as SETUP, plus the strobe low for X_ACCESS cycles.
  - Flash read: flash_oe_n. Flash write: flash_we_n.
  - Ethernet read: enet_rd_n. Ethernet write: enet_wr_n.
  - Reads capture ef_d_i into the port's rdata on the edge leaving ACCESS.
- HOLD: strobe high; CE/be, address and write data still driven; lasts X_HOLD cycles.
- Edge leaving HOLD:
  - state → IDLE
  - acked port's ack = 1 for exactly one cycle
  - CE/be released, ef_d_oe = 0
  - last_dev = granted device
- Latency: ack rises on edge (T + S + A + H) counted from the IDLE sampling edge (= edge 0). T = TURN if a switch occurs, else 0.
- Back-to-back: a requester re-raising req the cycle after ack is granted the next cycle. Minimum bus idle between transactions is one IDLE cycle.
- rdata holds its value until that port's next read completes. Write transactions leave rdata unchanged.
- Requests are not aborted. A req deasserted before ack is a protocol violation; the transaction still completes.
- flash_ce_n and the Ethernet enables are never simultaneously active. ef_d_oe = 0 in IDLE and TURN.

Test Plan:
- Reset → flash_ce_n/oe_n/we_n = 1, enet_rd_n/wr_n = 1, enet_be_n = F, ef_d_oe = 0. Assert rst mid-ACCESS → same values asynchronously, no ack.
- Flash read at addr 0x000100, defaults, first after reset → flash_ce_n low edges 0–7, flash_oe_n low edges 2–6, fl_rdata = ef_d_i value at edge 6, fl_ack high one cycle at edge 7, no TURN.
- Ethernet write addr 0x20, be = 4'b0011, wdata 0xDEADBEEF → enet_be_n = 4'b1100, ef_d_oe = 1 with 0xDEADBEEF edges 0–5, enet_wr_n low edges 1–4, en_ack at edge 5.
- fl_req and en_req both high from reset, held continuously:
  - grants alternate flash, enet, flash.
  - one TURN idle cycle (all strobes high, ef_d_oe = 0) before each switch.
  - flash_ce_n and enet_be_n never overlap.
- Two consecutive flash reads with fl_req re-raised right after ack → second SETUP starts two edges after the first ack, with no TURN.
- Parameter sweep FL_ACCESS = 1 and 15, TURN = 0 → strobe width equals FL_ACCESS exactly, and a device switch has no idle cycle beyond IDLE.

Source files
------------

// File: rtl/ef_bus_arbiter.sv
// ef_bus_arbiter: round-robin sharing of the Flash/Ethernet external bus with programmable strobe timing
`timescale 1ns/1ps
module ef_bus_arbiter #(
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int FL_SETUP  = 2,
    parameter int FL_ACCESS = 4,
    parameter int FL_HOLD   = 1,
    parameter int EN_SETUP  = 1,
    parameter int EN_ACCESS = 3,
    parameter int EN_HOLD   = 1,
    parameter int TURN      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fl_req,
    input  logic          fl_we,
    input  logic [AW-1:0] fl_addr,
    input  logic [DW-1:0] fl_wdata,
    output logic [DW-1:0] fl_rdata,
    output logic          fl_ack,
    input  logic          en_req,
    input  logic          en_we,
    input  logic [3:0]    en_be,
    input  logic [AW-1:0] en_addr,
    input  logic [DW-1:0] en_wdata,
    output logic [DW-1:0] en_rdata,
    output logic          en_ack,
    output logic [AW-1:0] ef_a,
    output logic [DW-1:0] ef_d_o,
    output logic          ef_d_oe,
    input  logic [DW-1:0] ef_d_i,
    output logic          flash_ce_n,
    output logic          flash_oe_n,
    output logic          flash_we_n,
    output logic          enet_rd_n,
    output logic          enet_wr_n,
    output logic [3:0]    enet_be_n
);
    typedef enum logic [2:0] {ST_IDLE, ST_TURN, ST_SETUP, ST_ACCESS, ST_HOLD} state_t;
    typedef enum logic [1:0] {DEV_NONE, DEV_FL, DEV_EN} dev_t;
    localparam logic [3:0] FS = 4'(FL_SETUP - 1);
    localparam logic [3:0] FA = 4'(FL_ACCESS - 1);
    localparam logic [3:0] FH = 4'(FL_HOLD - 1);
    localparam logic [3:0] ES = 4'(EN_SETUP - 1);
    localparam logic [3:0] EA = 4'(EN_ACCESS - 1);
    localparam logic [3:0] EH = 4'(EN_HOLD - 1);
    localparam logic [3:0] TL = 4'(TURN - 1);
    localparam bit HAS_TURN = TURN > 0;
    state_t state, state_d;
    dev_t last_dev, last_dev_d;
    logic [3:0] cnt, cnt_d, be_q, be_d;
    logic gnt, gnt_d, rr_pri, rr_pri_d, we_q, we_d, cap, done, bus, stb;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    // a port that is being acked this cycle is not yet making a new request
    logic fl_elig, en_elig, pick_en, turn;
    assign fl_elig = fl_req & ~fl_ack;
    assign en_elig = en_req & ~en_ack;
    assign pick_en = en_elig & (~fl_elig | rr_pri);
    assign turn = HAS_TURN && ((last_dev == DEV_FL && pick_en) || (last_dev == DEV_EN && !pick_en));
    assign bus = state_d == ST_SETUP || state_d == ST_ACCESS || state_d == ST_HOLD;
    assign stb = state_d == ST_ACCESS;
    // next-state, grant latching and phase counter reloads
    always_comb begin
        state_d = state;
        cnt_d = cnt - 4'd1;
        gnt_d = gnt;
        rr_pri_d = rr_pri;
        last_dev_d = last_dev;
        we_d = we_q;
        addr_d = addr_q;
        be_d = be_q;
        wdata_d = wdata_q;
        cap = 1'b0;
        done = 1'b0;
        unique case (state)
            ST_IDLE: if (fl_elig | en_elig) begin
                gnt_d = pick_en;
                rr_pri_d = (fl_elig & en_elig) ? ~rr_pri : rr_pri;
                we_d = pick_en ? en_we : fl_we;
                addr_d = pick_en ? en_addr : fl_addr;
                be_d = pick_en ? en_be : 4'hF;
                wdata_d = pick_en ? en_wdata : fl_wdata;
                state_d = turn ? ST_TURN : ST_SETUP;
                cnt_d = turn ? TL : (pick_en ? ES : FS);
            end
            ST_TURN: if (cnt == 4'd0) begin
                state_d = ST_SETUP;
                cnt_d = gnt ? ES : FS;
            end
            ST_SETUP: if (cnt == 4'd0) begin
                state_d = ST_ACCESS;
                cnt_d = gnt ? EA : FA;
            end
            ST_ACCESS: if (cnt == 4'd0) begin
                state_d = ST_HOLD;
                cnt_d = gnt ? EH : FH;
                cap = ~we_q;
            end
            ST_HOLD: if (cnt == 4'd0) begin
                state_d = ST_IDLE;
                done = 1'b1;
                last_dev_d = gnt ? DEV_EN : DEV_FL;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    // state plus every pad/port output registered from the next-state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt <= 4'd0;
            gnt <= 1'b0;
            rr_pri <= 1'b0;
            last_dev <= DEV_NONE;
            we_q <= 1'b0;
            addr_q <= '0;
            be_q <= 4'hF;
            wdata_q <= '0;
            fl_rdata <= '0;
            en_rdata <= '0;
            fl_ack <= 1'b0;
            en_ack <= 1'b0;
            ef_a <= '0;
            ef_d_o <= '0;
            ef_d_oe <= 1'b0;
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
            flash_we_n <= 1'b1;
            enet_rd_n <= 1'b1;
            enet_wr_n <= 1'b1;
            enet_be_n <= 4'hF;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            gnt <= gnt_d;
            rr_pri <= rr_pri_d;
            last_dev <= last_dev_d;
            we_q <= we_d;
            addr_q <= addr_d;
            be_q <= be_d;
            wdata_q <= wdata_d;
            fl_rdata <= (cap & ~gnt) ? ef_d_i : fl_rdata;
            en_rdata <= (cap & gnt) ? ef_d_i : en_rdata;
            fl_ack <= done & ~gnt;
            en_ack <= done & gnt;
            ef_a <= bus ? addr_d : ef_a;
            ef_d_o <= (bus & we_d) ? wdata_d : ef_d_o;
            ef_d_oe <= bus & we_d;
            flash_ce_n <= ~(bus & ~gnt_d);
            flash_oe_n <= ~(stb & ~gnt_d & ~we_d);
            flash_we_n <= ~(stb & ~gnt_d & we_d);
            enet_rd_n <= ~(stb & gnt_d & ~we_d);
            enet_wr_n <= ~(stb & gnt_d & we_d);
            enet_be_n <= (bus & gnt_d) ? ~be_d : 4'hF;
        end
    end
endmodule

// File: tb/tb_ef_bus_arbiter.sv
// tb_ef_bus_arbiter: directed edge-by-edge checks of ef_bus_arbiter timing and arbitration
`timescale 1ns/1ps
module tb_ef_bus_arbiter;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam logic [9:0] IDLE_V = 10'b1111111110;
    logic clk, rst;
    logic fl_req, fl_we, en_req, en_we, fl_ack, en_ack, ef_d_oe;
    logic [AW-1:0] fl_addr, en_addr, ef_a;
    logic [DW-1:0] fl_wdata, en_wdata, fl_rdata, en_rdata, ef_d_o, ef_d_i;
    logic [3:0] en_be, enet_be_n;
    logic flash_ce_n, flash_oe_n, flash_we_n, enet_rd_n, enet_wr_n;
    logic [9:0] idle_v;
    logic sfl_req, sen_req;
    logic [DW-1:0] s_fl_rdata [2], s_en_rdata [2], s_ef_d_o [2];
    logic [AW-1:0] s_ef_a [2];
    logic s_fl_ack [2], s_en_ack [2], s_ef_d_oe [2];
    logic s_flash_ce_n [2], s_flash_oe_n [2], s_flash_we_n [2], s_enet_rd_n [2], s_enet_wr_n [2];
    logic [3:0] s_enet_be_n [2];
    int k, n_cmp, n_bad;
    assign idle_v = {flash_ce_n, flash_oe_n, flash_we_n, enet_rd_n, enet_wr_n, enet_be_n, ef_d_oe};
    ef_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .fl_req(fl_req), .fl_we(fl_we), .fl_addr(fl_addr), .fl_wdata(fl_wdata),
        .fl_rdata(fl_rdata), .fl_ack(fl_ack),
        .en_req(en_req), .en_we(en_we), .en_be(en_be), .en_addr(en_addr), .en_wdata(en_wdata),
        .en_rdata(en_rdata), .en_ack(en_ack),
        .ef_a(ef_a), .ef_d_o(ef_d_o), .ef_d_oe(ef_d_oe), .ef_d_i(ef_d_i),
        .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
        .enet_rd_n(enet_rd_n), .enet_wr_n(enet_wr_n), .enet_be_n(enet_be_n)
    );
    for (genvar g = 0; g < 2; g++) begin : sw
        ef_bus_arbiter #(.AW(AW), .DW(DW), .FL_ACCESS(g == 0 ? 1 : 15), .TURN(0)) u (
            .clk(clk), .rst(rst),
            .fl_req(sfl_req), .fl_we(fl_we), .fl_addr(fl_addr), .fl_wdata(fl_wdata),
            .fl_rdata(s_fl_rdata[g]), .fl_ack(s_fl_ack[g]),
            .en_req(sen_req), .en_we(en_we), .en_be(en_be), .en_addr(en_addr), .en_wdata(en_wdata),
            .en_rdata(s_en_rdata[g]), .en_ack(s_en_ack[g]),
            .ef_a(s_ef_a[g]), .ef_d_o(s_ef_d_o[g]), .ef_d_oe(s_ef_d_oe[g]), .ef_d_i(ef_d_i),
            .flash_ce_n(s_flash_ce_n[g]), .flash_oe_n(s_flash_oe_n[g]), .flash_we_n(s_flash_we_n[g]),
            .enet_rd_n(s_enet_rd_n[g]), .enet_wr_n(s_enet_wr_n[g]), .enet_be_n(s_enet_be_n[g])
        );
    end
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
        k = k + 1;
        ef_d_i = {16'hCAFE, k[15:0]};
    endtask
    task automatic reset_dut;
        rst = 1'b1;
        fl_req = 1'b0;
        en_req = 1'b0;
        sfl_req = 1'b0;
        sen_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        k = -1;
    endtask
    initial begin
        int oe_cnt [2], fa [2], eb [2], ea [2], ov;
        n_cmp = 0;
        n_bad = 0;
        k = 0;
        ef_d_i = '0;
        fl_we = 1'b0;
        fl_addr = 'h100;
        fl_wdata = '0;
        en_we = 1'b0;
        en_be = 4'hF;
        en_addr = '0;
        en_wdata = '0;
        reset_dut;
        check("rst_ctrl", idle_v, IDLE_V);
        check("rst_addr", ef_a, 0);
        check("rst_dout", ef_d_o, 0);
        check("rst_acks", {fl_ack, en_ack}, 2'b00);
        check("rst_rdata", {fl_rdata, en_rdata}, 64'h0);
        fl_req = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick;
            check("frd_ce", flash_ce_n, e >= 7);
            check("frd_oe", flash_oe_n, !(e >= 2 && e <= 5));
            check("frd_ack", fl_ack, e == 7);
            if (e == 3) check("frd_addr", ef_a, 'h100);
            if (e == 3) check("frd_doe", ef_d_oe, 0);
            if (e == 6) check("frd_rdata", fl_rdata, 32'hCAFE0005);
            if (e == 7) fl_req = 1'b0;
        end
        reset_dut;
        en_we = 1'b1;
        en_be = 4'b0011;
        en_addr = 'h20;
        en_wdata = 32'hDEADBEEF;
        en_req = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick;
            check("ewr_be", enet_be_n, e <= 4 ? 4'b1100 : 4'hF);
            check("ewr_doe", ef_d_oe, e <= 4);
            check("ewr_wr", enet_wr_n, !(e >= 1 && e <= 3));
            check("ewr_ack", en_ack, e == 5);
            if (e == 2) check("ewr_dout", ef_d_o, 32'hDEADBEEF);
            if (e == 2) check("ewr_addr", ef_a, 'h20);
            if (e == 2) check("ewr_ce", flash_ce_n, 1);
            if (e == 5) en_req = 1'b0;
        end
        check("ewr_rdata", en_rdata, 0);
        reset_dut;
        fl_we = 1'b1;
        fl_wdata = 32'h12345678;
        fl_addr = 'h200;
        en_we = 1'b0;
        en_be = 4'hF;
        en_addr = 'h40;
        fl_req = 1'b1;
        en_req = 1'b1;
        ov = 0;
        for (int e = 0; e <= 31; e++) begin
            tick;
            check("rr_ack", {fl_ack, en_ack}, (e == 7 || e == 23) ? 2'b10 : (e == 14 || e == 30) ? 2'b01 : 2'b00);
            if (!flash_ce_n && enet_be_n != 4'hF) ov++;
            if (e == 8 || e == 15 || e == 24) check("rr_turn", idle_v, IDLE_V);
            if (e == 10) check("rr_enet_rd", enet_rd_n, 0);
            if (e == 13) check("rr_en_rdata", en_rdata, 32'hCAFE000C);
            if (e == 18) check("rr_flash_we", {flash_we_n, flash_oe_n}, 2'b01);
            if (e == 18) check("rr_flash_d", ef_d_o, 32'h12345678);
            if (e == 23) check("rr_fl_rdata", fl_rdata, 0);
        end
        check("rr_overlap", ov, 0);
        reset_dut;
        fl_we = 1'b0;
        fl_addr = 'h100;
        fl_req = 1'b1;
        for (int e = 0; e <= 17; e++) begin
            tick;
            check("b2b_ce", flash_ce_n, !(e <= 6 || (e >= 9 && e <= 15)));
            check("b2b_ack", fl_ack, e == 7 || e == 16);
            if (e == 10 || e == 11) check("b2b_oe", flash_oe_n, e == 10);
            fl_req = !(e == 7 || e >= 16);
        end
        reset_dut;
        fl_req = 1'b1;
        repeat (4) tick;
        check("arst_pre", flash_oe_n, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ctrl", idle_v, IDLE_V);
        check("arst_ack", fl_ack, 0);
        fl_req = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick;
            check("arst_quiet", {fl_ack, flash_ce_n, fl_rdata}, {2'b01, 32'h0});
        end
        reset_dut;
        sfl_req = 1'b1;
        sen_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            oe_cnt[i] = 0;
            fa[i] = -1;
            eb[i] = -1;
            ea[i] = -1;
        end
        for (int e = 0; e < 30; e++) begin
            tick;
            for (int i = 0; i < 2; i++) begin
                if (fa[i] < 0 && !s_flash_oe_n[i]) oe_cnt[i]++;
                if (fa[i] < 0 && s_fl_ack[i]) fa[i] = e;
                if (eb[i] < 0 && s_enet_be_n[i] != 4'hF) eb[i] = e;
                if (ea[i] < 0 && s_en_ack[i]) ea[i] = e;
            end
        end
        for (int i = 0; i < 2; i++) begin
            int a;
            a = i == 0 ? 1 : 15;
            check("sw_width", oe_cnt[i], a);
            check("sw_fl_ack", fa[i], 3 + a);
            check("sw_switch", eb[i], 4 + a);
            check("sw_en_ack", ea[i], 9 + a);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
